// File: rtl/req_encoder8_pkg.sv
// Shared widths and FSM state type for the 8-request priority encoder.
package req_encoder8_pkg;
  localparam int REQ_W  = 8;
  localparam int CODE_W = 3;

  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;
endpackage

// File: rtl/req_encoder8_if.sv
// Request/offer bus between a requester+consumer (master) and the encoder (slave).
interface req_encoder8_if;
  import req_encoder8_pkg::*;

  logic              en;
  logic [REQ_W-1:0]  req;
  logic              ready;
  logic [CODE_W-1:0] code;
  logic              valid;
  logic [REQ_W-1:0]  pending;
  logic              busy;
  logic              overrun;

  modport master (output en, req, ready, input code, valid, pending, busy, overrun);
  modport slave  (input en, req, ready, output code, valid, pending, busy, overrun);
endinterface

// File: rtl/req_encoder8_prio_enc8to3.sv
// Combinational highest-set-index encoder; bit 7 has top priority.
module prio_enc8to3
  import req_encoder8_pkg::*;
(
  input  logic [REQ_W-1:0]  vec,
  output logic [CODE_W-1:0] idx,
  output logic              any
);
  always_comb begin
    idx = '0;
    any = |vec;
    // ascending scan so the last (highest) set bit wins
    for (int i = 0; i < REQ_W; i++)
      if (vec[i]) idx = CODE_W'(i);
  end
endmodule

// File: rtl/req_encoder8.sv
// Sticky request capture with a registered priority offer and valid/ready handshake.
module req_encoder8
  import req_encoder8_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  req_encoder8_if.slave  bus
);
  state_t            state_q, state_d;
  logic [REQ_W-1:0]  pending_q, pending_d, clr, cap;
  logic [CODE_W-1:0] code_q, code_d, cur_idx, nxt_idx;
  logic              valid_q, overrun_q, cur_any, nxt_any, hs;

  assign hs  = valid_q & bus.ready;
  assign clr = hs ? (REQ_W'(1) << code_q) : '0;
  assign cap = bus.en ? bus.req : '0;
  // a same-edge capture re-sets the bit being cleared
  assign pending_d = (pending_q & ~clr) | cap;

  prio_enc8to3 u_cur (.vec(pending_q), .idx(cur_idx), .any(cur_any));
  prio_enc8to3 u_nxt (.vec(pending_d), .idx(nxt_idx), .any(nxt_any));

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    case (state_q)
      IDLE: if (cur_any) begin
        state_d = OFFER;
        code_d  = cur_idx;
      end
      OFFER: if (hs) begin
        if (nxt_any) code_d  = nxt_idx;
        else         state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      code_q    <= code_d;
      valid_q   <= (state_d == OFFER);
      overrun_q <= |(cap & pending_q & ~clr);
    end
  end

  assign bus.code    = code_q;
  assign bus.valid   = valid_q;
  assign bus.pending = pending_q;
  assign bus.busy    = |pending_q;
  assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_req_encoder8.sv
// Directed-vector bench for req_encoder8 with hand-computed expectations.
module tb_req_encoder8;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  req_encoder8_if bus ();
  req_encoder8 dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [2:0] c, input logic [7:0] p);
    chk({tag, ".valid"},   {7'd0, bus.valid}, {7'd0, v});
    chk({tag, ".code"},    {5'd0, bus.code},  {5'd0, c});
    chk({tag, ".pending"}, bus.pending, p);
    chk({tag, ".busy"},    {7'd0, bus.busy},  {7'd0, |p});
  endtask

  initial begin
    rst = 1'b1; bus.en = 1'b1; bus.req = 8'h00; bus.ready = 1'b0;
    tick(); tick();
    chk_out("reset", 1'b0, 3'd0, 8'h00);
    chk("reset.overrun", {7'd0, bus.overrun}, 8'h00);
    rst = 1'b0;

    // single request, ready held high
    bus.req = 8'h10; bus.ready = 1'b1;
    tick(); chk_out("single.cap", 1'b0, 3'd0, 8'h10);
    bus.req = 8'h00;
    tick(); chk_out("single.offer", 1'b1, 3'd4, 8'h10);
    tick(); chk_out("single.done", 1'b0, 3'd4, 8'h00);

    // all eight at once, served high to low with no bubble
    bus.req = 8'hFF;
    tick(); chk_out("all.cap", 1'b0, 3'd4, 8'hFF);
    bus.req = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      tick();
      chk("all.valid", {7'd0, bus.valid}, 8'h01);
      chk("all.code", {5'd0, bus.code}, 8'(i));
    end
    tick(); chk_out("all.done", 1'b0, 3'd0, 8'h00);

    // no preemption by a later higher request
    bus.ready = 1'b0; bus.req = 8'h01;
    tick(); chk_out("nopre.cap", 1'b0, 3'd0, 8'h01);
    bus.req = 8'h80;
    tick(); chk_out("nopre.offer", 1'b1, 3'd0, 8'h81);
    bus.req = 8'h00;
    tick(); chk_out("nopre.hold", 1'b1, 3'd0, 8'h81);
    bus.ready = 1'b1;
    tick(); chk_out("nopre.next", 1'b1, 3'd7, 8'h80);
    tick(); chk_out("nopre.done", 1'b0, 3'd7, 8'h00);
    bus.ready = 1'b0;

    // overrun, then set-wins on handshake
    bus.req = 8'h04;
    tick(); chk("ovr.cap", {7'd0, bus.overrun}, 8'h00);
    tick(); chk("ovr.pulse", {7'd0, bus.overrun}, 8'h01);
    chk_out("ovr.state", 1'b1, 3'd2, 8'h04);
    bus.req = 8'h00;
    tick(); chk("ovr.drop", {7'd0, bus.overrun}, 8'h00);
    bus.req = 8'h04; bus.ready = 1'b1;
    tick(); chk("setwins.ovr", {7'd0, bus.overrun}, 8'h00);
    chk_out("setwins", 1'b1, 3'd2, 8'h04);
    bus.req = 8'h00;
    tick(); chk_out("setwins.done", 1'b0, 3'd2, 8'h00);
    bus.ready = 1'b0;

    // capture disabled; queued work still drains
    bus.en = 1'b0; bus.req = 8'hFF;
    tick(); tick(); chk_out("en0", 1'b0, 3'd2, 8'h00);
    bus.en = 1'b1; bus.req = 8'h08;
    tick(); chk_out("en0.cap", 1'b0, 3'd2, 8'h08);
    bus.en = 1'b0; bus.req = 8'hFF;
    tick(); chk_out("en0.offer", 1'b1, 3'd3, 8'h08);
    bus.ready = 1'b1;
    tick(); chk_out("en0.drain", 1'b0, 3'd3, 8'h00);
    bus.ready = 1'b0; bus.en = 1'b1; bus.req = 8'h00;

    // asynchronous reset during an offer
    bus.req = 8'hA0;
    tick(); bus.req = 8'h00;
    tick(); chk_out("rst.pre", 1'b1, 3'd7, 8'hA0);
    #2 rst = 1'b1; bus.ready = 1'b1;
    #1 chk_out("rst.async", 1'b0, 3'd0, 8'h00);
    tick(); chk_out("rst.hold", 1'b0, 3'd0, 8'h00);
    rst = 1'b0;
    tick(); tick(); chk_out("rst.after", 1'b0, 3'd0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
